// File: rtl/sha256d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256d_pkg
// Description : Shared types, constants and helpers for the SHA-256(d) engine.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256d_pkg;

    typedef logic [255:0] word256_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_FINAL  = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    localparam word256_t SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Padding tail for a 32-byte message: 0x80 marker, zeros, length 256 bits.
    localparam word256_t PAD_256 = {32'h80000000, 192'h0, 32'h00000100};

    localparam logic [0:63][31:0] c_sha256_k = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256.sv
`default_nettype none
// ============================================================================
// Module      : sha256
// Description : Fully combinational SHA-256 compression of one 512-bit block.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256
    import sha256d_pkg::*;
(
    input  logic [511:0] data,
    input  word256_t     state,
    output word256_t     next_state
);

    function automatic word256_t f_compress(input logic [511:0] blk, input word256_t st);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] s0, s1, t1, t2, ch, maj;
        for (int i = 0; i < 16; i++) begin
            w[i] = blk[511 - 32*i -: 32];
        end
        for (int i = 16; i < 64; i++) begin
            s0   = ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = st[255:224]; b = st[223:192]; c = st[191:160]; d = st[159:128];
        e = st[127:96];  f = st[95:64];   g = st[63:32];   h = st[31:0];
        for (int i = 0; i < 64; i++) begin
            s1  = ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25);
            ch  = (e & f) ^ (~e & g);
            t1  = h + s1 + ch + c_sha256_k[i[5:0]] + w[i];
            s0  = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
            maj = (a & b) ^ (a & c) ^ (b & c);
            t2  = s0 + maj;
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96]  + e, st[95:64]   + f, st[63:32]   + g, st[31:0]    + h};
    endfunction

    assign next_state = f_compress(data, state);

endmodule
`default_nettype wire

// File: rtl/sha256d_stream.sv
`default_nettype none
// ============================================================================
// Module      : sha256d_stream
// Description : Block-streaming SHA-256 / SHA-256d engine, one block per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256d_stream
    import sha256d_pkg::*;
#(
    parameter int MAX_BLOCKS = 8,
    parameter int DOUBLE     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         out_err,
    output logic         busy
);

    localparam int                 c_cnt_w   = $clog2(MAX_BLOCKS + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_BLOCKS);
    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(MAX_BLOCKS + 1);

    state_t             r_state;
    word256_t           r_chain;
    word256_t           r_digest;
    logic [c_cnt_w-1:0] r_count;
    logic               r_err;

    logic [511:0]       w_cmp_data;
    word256_t           w_cmp_state;
    word256_t           w_cmp_next;
    logic               w_accept;

    // Outputs are gated by rst_n so nothing is presented while reset is held.
    assign in_ready   = rst_n && ((r_state == ST_IDLE) || (r_state == ST_ABSORB));
    assign out_valid  = rst_n && (r_state == ST_OUT);
    assign busy       = rst_n && (r_state != ST_IDLE);
    assign out_err    = out_valid && r_err;
    assign out_digest = r_digest;
    assign w_accept   = in_valid && in_ready;

    // One compressor serves both the absorb path and the outer hash of SHA-256d.
    always_comb begin
        w_cmp_data  = in_block;
        w_cmp_state = (r_state == ST_IDLE) ? SHA256_H0 : r_chain;
        if (r_state == ST_FINAL) begin
            w_cmp_data  = {r_chain, PAD_256};
            w_cmp_state = SHA256_H0;
        end
    end

    sha256 u_sha256 (
        .data       (w_cmp_data),
        .state      (w_cmp_state),
        .next_state (w_cmp_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_chain  <= SHA256_H0;
            r_digest <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ABSORB: begin
                    if (w_accept) begin
                        r_chain <= w_cmp_next;
                        if (r_count == c_cnt_max) begin
                            r_err <= 1'b1;
                        end
                        if (r_count != c_cnt_sat) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (!in_last) begin
                            r_state <= ST_ABSORB;
                        end else if (DOUBLE != 0) begin
                            r_state <= ST_FINAL;
                        end else begin
                            r_digest <= w_cmp_next;
                            r_state  <= ST_OUT;
                        end
                    end
                end
                ST_FINAL: begin
                    r_digest <= w_cmp_next;
                    r_state  <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_chain <= SHA256_H0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256d_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256d_stream
// Description : Scoreboard bench for single, double and block-limited engines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256d_stream;

    typedef struct {
        logic [255:0] dig;
        logic         err;
        bit           chk_dig;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [511:0] in_block = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b1;
    logic [1:0]   sel = 2'd0;

    logic [2:0]   w_iv, w_ir, w_ov, w_oe, w_bz;
    logic [255:0] w_od [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_exp[$];

    localparam logic [511:0] c_abc   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] c_empty = {32'h80000000, 480'h0};
    localparam logic [511:0] c_nist1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_nist2 = {448'h0, 64'h1c0};

    localparam logic [255:0] c_abc_s   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_abc_d   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] c_nist_s  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] c_empty_d = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

    always #5 clk = ~clk;

    assign w_iv[0] = in_valid && (sel == 2'd0);
    assign w_iv[1] = in_valid && (sel == 2'd1);
    assign w_iv[2] = in_valid && (sel == 2'd2);

    sha256d_stream #(.MAX_BLOCKS(8), .DOUBLE(0)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv[0]), .in_ready(w_ir[0]),
        .in_block(in_block), .in_last(in_last), .out_valid(w_ov[0]),
        .out_ready(out_ready), .out_digest(w_od[0]), .out_err(w_oe[0]), .busy(w_bz[0]));

    sha256d_stream #(.MAX_BLOCKS(8), .DOUBLE(1)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv[1]), .in_ready(w_ir[1]),
        .in_block(in_block), .in_last(in_last), .out_valid(w_ov[1]),
        .out_ready(out_ready), .out_digest(w_od[1]), .out_err(w_oe[1]), .busy(w_bz[1]));

    sha256d_stream #(.MAX_BLOCKS(2), .DOUBLE(1)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv[2]), .in_ready(w_ir[2]),
        .in_block(in_block), .in_last(in_last), .out_valid(w_ov[2]),
        .out_ready(out_ready), .out_digest(w_od[2]), .out_err(w_oe[2]), .busy(w_bz[2]));

    wire         w_ready = w_ir[sel];
    wire         w_valid = w_ov[sel];
    wire         w_err   = w_oe[sel];
    wire         w_busy  = w_bz[sel];
    wire [255:0] w_dig   = w_od[sel];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [511:0] blk, input logic last);
        @(negedge clk);
        check("in_ready_before_accept", 256'(w_ready), 256'(1));
        in_valid = 1'b1;
        in_block = blk;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [255:0] dig, input logic err, input bit chk);
        exp_t e;
        e.dig = dig; e.err = err; e.chk_dig = chk;
        q_exp.push_back(e);
    endtask

    // Waits for out_valid, scores it, optionally stalls the consumer, then
    // completes the handshake and confirms the return to IDLE.
    task automatic wait_out(input int lat, input int hold);
        int   n = 0;
        exp_t e;
        do begin
            @(negedge clk);
            n++;
            if (!w_valid) begin
                check("err_low_without_valid", 256'(w_err), 256'(0));
                if (n == 1 && lat == 2) check("final_in_ready", 256'(w_ready), 256'(0));
            end
        end while (!w_valid && n < 20);
        check("latency", 256'(n), 256'(lat));
        if (q_exp.size() == 0) begin
            check("scoreboard_empty", 256'(1), 256'(0));
            out_ready = 1'b1;
            return;
        end
        e = q_exp.pop_front();
        if (!w_valid) begin
            out_ready = 1'b1;
            return;
        end
        if (e.chk_dig) check("digest", w_dig, e.dig);
        check("out_err", 256'(w_err), 256'(e.err));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 256'(w_valid), 256'(1));
            check("hold_in_ready", 256'(w_ready), 256'(0));
            if (e.chk_dig) check("hold_digest", w_dig, e.dig);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_handshake", 256'(w_busy), 256'(0));
        check("valid_low_after_handshake", 256'(w_valid), 256'(0));
        check("ready_after_handshake", 256'(w_ready), 256'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_seen;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("reset_out_valid", 256'(w_valid), 256'(0));
        check("reset_in_ready", 256'(w_ready), 256'(0));
        check("reset_busy", 256'(w_busy), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 256'(w_ready), 256'(1));

        // "abc", single
        sel = 2'd0;
        push(c_abc_s, 1'b0, 1'b1);
        send(c_abc, 1'b1);
        wait_out(1, 0);

        // "abc", double
        sel = 2'd1;
        push(c_abc_d, 1'b0, 1'b1);
        send(c_abc, 1'b1);
        wait_out(2, 0);

        // Two-block NIST vector with a gap between blocks
        sel = 2'd0;
        send(c_nist1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("absorb_wait_ready", 256'(w_ready), 256'(1));
            check("absorb_wait_busy", 256'(w_busy), 256'(1));
            check("absorb_wait_valid", 256'(w_valid), 256'(0));
        end
        push(c_nist_s, 1'b0, 1'b1);
        send(c_nist2, 1'b1);
        wait_out(1, 0);

        // Empty message, double, consumer stalls for 5 cycles
        sel = 2'd1;
        out_ready = 1'b0;
        push(c_empty_d, 1'b0, 1'b1);
        send(c_empty, 1'b1);
        wait_out(2, 5);

        // Block limit: three blocks exceed MAX_BLOCKS=2
        sel = 2'd2;
        push('0, 1'b1, 1'b0);
        send(c_abc, 1'b0);
        send(c_abc, 1'b0);
        send(c_abc, 1'b1);
        wait_out(2, 0);

        // Exactly MAX_BLOCKS blocks is legal
        push('0, 1'b0, 1'b0);
        send(c_nist1, 1'b0);
        send(c_nist2, 1'b1);
        wait_out(2, 0);

        // Error clears for the next message
        push(c_abc_d, 1'b0, 1'b1);
        send(c_abc, 1'b1);
        wait_out(2, 0);

        // Reset mid-message abandons it
        sel = 2'd1;
        send(c_nist1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_valid", 256'(w_valid), 256'(0));
        check("midreset_ready", 256'(w_ready), 256'(0));
        check("midreset_busy", 256'(w_busy), 256'(0));
        rst_n = 1'b1;
        n_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (w_valid) n_seen++;
        end
        check("no_digest_after_reset", 256'(n_seen), 256'(0));
        check("idle_after_midreset", 256'(w_busy), 256'(0));
        push(c_abc_d, 1'b0, 1'b1);
        send(c_abc, 1'b1);
        wait_out(2, 0);

        // Back-to-back single messages
        sel = 2'd0;
        push(c_abc_s, 1'b0, 1'b1);
        send(c_abc, 1'b1);
        wait_out(1, 0);
        push(c_nist_s, 1'b0, 1'b1);
        send(c_nist1, 1'b0);
        send(c_nist2, 1'b1);
        wait_out(1, 0);

        check("scoreboard_drained", 256'(q_exp.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
